// File: rtl/ndp_feed_scheduler.sv
// ndp_feed_scheduler: job sequencer in front of the NDP compute unit.
// It accepts one tile command, streams cmd_len rows of A/B operand addresses
// into the buffer, raises in_done_flag, waits for calc_done_flag and then
// presents the result with a valid/ready handshake.
// Optional WAIT watchdog with an ERR state: define NDP_SCHED_TIMEOUT_EN.
module ndp_feed_scheduler #(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_a_base,
    input  logic [ADDR_W-1:0] cmd_b_base,
    input  logic [1:0]        cmd_simd,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_a_addr,
    output logic [ADDR_W-1:0] rd_b_addr,
    output logic              feed_en,
    output logic              in_done_flag,
    output logic [1:0]        SIMD_control,
    input  logic              calc_done_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_WAIT,
        S_RESULT,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [1:0]        r_simd;
    logic              r_cmd_ready;
    logic              r_feed_en;
    logic              w_accept;
    logic              w_last;
    logic              w_wd_expired;
    logic              w_rd_en;
    logic              w_in_done;
    logic              w_res_valid;
    logic              w_busy;

    assign w_accept = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
    assign w_last   = (r_cnt == r_len - LEN_W'(1));

`ifdef NDP_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] r_wdog;

    // Count cycles spent in WAIT; restart from zero whenever WAIT is left
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + WD_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_wd_expired = (r_state == S_WAIT) && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
    assign err          = (r_state == S_ERR);
`else
    logic [1:0] w_unused_cfg;

    assign w_unused_cfg = {err_clr, TIMEOUT_CYC[0]};
    assign w_wd_expired = 1'b0;
    assign err          = 1'b0;
`endif

    // State register plus the registered cmd_ready and the one-stage feed_en delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_feed_en   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_feed_en   <= (r_state == S_FEED);
        end
    end

    // Latch the command on acceptance and advance the step counter while feeding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_simd   <= 2'b00;
        end else if (w_accept) begin
            r_len    <= cmd_len;
            r_cnt    <= '0;
            r_a_base <= cmd_a_base;
            r_b_base <= cmd_b_base;
            r_simd   <= cmd_simd;
        end else if (r_state == S_FEED) begin
            r_cnt <= r_cnt + LEN_W'(1);
        end
    end

    // Next-state and Moore outputs of the job sequencer
    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_in_done   = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_accept && (cmd_len != '0)) begin
                    w_next = S_FEED;
                end
            end
            S_FEED: begin
                w_rd_en = 1'b1;
                if (w_last) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                w_in_done = 1'b1;
                if (calc_done_flag) begin
                    w_next = S_RESULT;
                end else if (w_wd_expired) begin
                    w_next = S_ERR;
                end
            end
            S_RESULT: begin
                w_res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_ERR: begin
`ifdef NDP_SCHED_TIMEOUT_EN
                if (err_clr) begin
                    w_next = S_IDLE;
                end
`else
                w_next = S_IDLE;
`endif
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign cmd_ready    = r_cmd_ready;
    assign rd_en        = w_rd_en;
    assign rd_a_addr    = r_a_base + ADDR_W'(r_cnt);
    assign rd_b_addr    = r_b_base + ADDR_W'(r_cnt);
    assign feed_en      = r_feed_en;
    assign in_done_flag = w_in_done;
    assign SIMD_control = r_simd;
    assign res_valid    = w_res_valid;
    assign busy         = w_busy;

endmodule
